// File: rtl/reflet_bus_arbiter_if.sv
// Two-master shared memory bus bundle. Suffixes are from the arbiter's side:
// the slave modport is the arbiter, the master modport is the requesters plus memory.
interface reflet_bus_arbiter_if #(
  parameter int WORDSIZE = 16
);
  logic                m0_req_i;
  logic [WORDSIZE-1:0] m0_addr_i;
  logic [WORDSIZE-1:0] m0_data_out_i;
  logic                m0_write_en_i;
  logic                m0_ready_o;
  logic [WORDSIZE-1:0] m0_data_in_o;

  logic                m1_req_i;
  logic [WORDSIZE-1:0] m1_addr_i;
  logic [WORDSIZE-1:0] m1_data_out_i;
  logic                m1_write_en_i;
  logic                m1_ready_o;
  logic [WORDSIZE-1:0] m1_data_in_o;

  logic [WORDSIZE-1:0] bus_addr_o;
  logic [WORDSIZE-1:0] bus_data_out_o;
  logic                bus_write_en_o;
  logic [WORDSIZE-1:0] bus_data_in_i;
  logic [1:0]          owner_o;

  modport slave (
    input  m0_req_i, m0_addr_i, m0_data_out_i, m0_write_en_i,
    output m0_ready_o, m0_data_in_o,
    input  m1_req_i, m1_addr_i, m1_data_out_i, m1_write_en_i,
    output m1_ready_o, m1_data_in_o,
    output bus_addr_o, bus_data_out_o, bus_write_en_o, owner_o,
    input  bus_data_in_i
  );

  modport master (
    output m0_req_i, m0_addr_i, m0_data_out_i, m0_write_en_i,
    input  m0_ready_o, m0_data_in_o,
    output m1_req_i, m1_addr_i, m1_data_out_i, m1_write_en_i,
    input  m1_ready_o, m1_data_in_o,
    input  bus_addr_o, bus_data_out_o, bus_write_en_o, owner_o,
    output bus_data_in_i
  );
endinterface

// File: rtl/reflet_bus_arbiter.sv
// Round-robin arbiter sharing one synchronous memory bus between two masters,
// with a bounded hold time per owner and read data steered to the issuing master.
//
// state | meaning
// IDLE  | nobody owns the bus, all bus outputs zero
// OWN0  | master 0 drives the bus
// OWN1  | master 1 drives the bus
module reflet_bus_arbiter #(
  parameter int WORDSIZE = 16,
  parameter int HOLD_MAX = 8
) (
  input logic                  clk_i,
  input logic                  reset_i,
  reflet_bus_arbiter_if.slave  bus
);

  localparam int HW = $clog2(HOLD_MAX) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic          last_owner_q, last_owner_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    prev_owner_q, prev_owner_d;

  logic   own_req, oth_req;
  state_t oth_state;

  always_comb begin
    own_req   = (state_q == OWN1) ? bus.m1_req_i : bus.m0_req_i;
    oth_req   = (state_q == OWN1) ? bus.m0_req_i : bus.m1_req_i;
    oth_state = (state_q == OWN1) ? OWN0 : OWN1;
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    hold_d       = hold_q;
    prev_owner_d = 2'b00;
    case (state_q)
      IDLE: begin
        if (bus.m0_req_i && bus.m1_req_i) begin
          state_d = last_owner_q ? OWN0 : OWN1;
        end else if (bus.m0_req_i) begin
          state_d = OWN0;
        end else if (bus.m1_req_i) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        prev_owner_d = own_req ? state_q : 2'b00;
        // A dropped request takes priority over hold expiry in the same cycle.
        if (!own_req) begin
          state_d = oth_req ? oth_state : IDLE;
        end else if (oth_req && (hold_q == HOLD_LAST)) begin
          state_d = oth_state;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      hold_d = '0;
      if (state_q != IDLE) begin
        last_owner_d = (state_q == OWN1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      hold_q       <= '0;
      prev_owner_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      hold_q       <= hold_d;
      prev_owner_q <= prev_owner_d;
    end
  end

  // Bus steering depends only on the registered owner and that owner's own request.
  always_comb begin
    bus.bus_addr_o     = '0;
    bus.bus_data_out_o = '0;
    bus.bus_write_en_o = 1'b0;
    case (state_q)
      OWN0: begin
        bus.bus_addr_o     = bus.m0_addr_i;
        bus.bus_data_out_o = bus.m0_data_out_i;
        bus.bus_write_en_o = bus.m0_write_en_i & bus.m0_req_i;
      end
      OWN1: begin
        bus.bus_addr_o     = bus.m1_addr_i;
        bus.bus_data_out_o = bus.m1_data_out_i;
        bus.bus_write_en_o = bus.m1_write_en_i & bus.m1_req_i;
      end
      default: ;
    endcase
  end

  assign bus.m0_ready_o   = (state_q == OWN0) & bus.m0_req_i;
  assign bus.m1_ready_o   = (state_q == OWN1) & bus.m1_req_i;
  assign bus.m0_data_in_o = (prev_owner_q == 2'b01) ? bus.bus_data_in_i : '0;
  assign bus.m1_data_in_o = (prev_owner_q == 2'b10) ? bus.bus_data_in_i : '0;
  assign bus.owner_o      = state_q;

endmodule

// File: doc/reflet_bus_arbiter.md
Name: reflet_bus_arbiter

Overview:
- Shares one synchronous memory bus (ROM, RAM, memory testers with OR-combined data) between two masters.
- Master 0 is normally reflet_cpu. Its stall input (enable) is driven from m0_ready.
- Master 1 is a secondary requester, such as a DMA or debug loader.
- Ownership is registered and round-robin fair, with a bounded hold time per owner.
- Read data returned one cycle after the address is steered back to the master that issued it.

Parameters:
- wordsize, 16, width of address and data buses.
- hold_max, 8, maximum consecutive owned cycles while the other master is waiting. Must be >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- m0_req  input  1  master 0 requests the bus (CPU: tie high)
- m0_addr  input  wordsize  master 0 address
- m0_data_out  input  wordsize  master 0 write data
- m0_write_en  input  1  master 0 write strobe
- m0_ready  output  1  master 0 owns the bus this cycle (drive CPU enable)
- m0_data_in  output  wordsize  read data for master 0
- m1_req, m1_addr, m1_data_out, m1_write_en, m1_ready, m1_data_in: same as the m0 ports, for master 1
- bus_addr  output  wordsize  shared bus address
- bus_data_out  output  wordsize  shared bus write data
- bus_write_en  output  1  shared bus write strobe
- bus_data_in  input  wordsize  OR-combined memory read data, valid one cycle after address
- owner  output  2  00 idle, 01 master 0, 10 master 1

Behaviour:
- State register: IDLE, OWN0, OWN1. Also registered: last_owner (1 bit), hold counter (ceil(log2(hold_max))+1 bits), prev_owner (2 bits).
- Reset (async, reset=0):
  - state IDLE, last_owner=1 (so master 0 wins the first tie), hold=0, prev_owner=00.
  - All outputs 0 while in reset.
  - Reset mid-burst aborts immediately. No write is issued in the reset cycle.
- IDLE:
  - Outputs zero.
  - Next state: both req -> grant the master != last_owner; one req -> that master; none -> IDLE.
  - Grant latency from req to ready: 1 cycle.
- OWNx:
  - mx_ready = mx_req.
  - bus_addr / bus_data_out = mx signals.
  - bus_write_en = mx_write_en & mx_req.
  - Non-owner: ready=0. Its addr and write_en are ignored.
- Transitions from OWNx, evaluated every cycle; the first matching rule wins:
  - mx_req=0 -> other req ? OWN(other) : IDLE. The bus is idle this cycle (one-cycle bubble).
  - Other req=1 and hold==hold_max-1 -> OWN(other), hold=0.
  - Otherwise stay in OWNx; hold increments, saturating at hold_max-1.
  - On any state change, last_owner takes the leaving owner and hold is cleared.
- Read steering:
  - prev_owner <= owner, but only when the owner's req=1; otherwise 00.
  - mx_data_in = bus_data_in when prev_owner selects x; otherwise 0.
  - The zero default preserves OR-bus composition.
  - On a switch cycle, data for the last access of the old owner still goes to the old owner.
- Simultaneous events:
  - A drop of req and the hold expiry in the same cycle: handled as a drop.
  - hold_max=1 with both masters requesting: ownership alternates every cycle.
- No combinational path from any mx_req to bus_write_en other than through the owner's own req.

Test Plan:
- Reset low 100 time units, then high, m0_req=1, m1_req=0 -> owner=00 and all outputs 0 during reset; owner=01 and m0_ready=1 from the 1st rising edge after release; m1_ready stays 0.
- hold_max=4, both req high from reset release -> owner pattern 01,01,01,01,10,10,10,10,01…; each master sees exactly 4 ready cycles per turn.
- CPU plus a 1-cycle registered ROM, m1 reading addr 0x0010 (ROM holds 0xA5) on its last owned cycle -> the next cycle m1_data_in=0xA5 and m0_data_in=0, even though owner=01.
- m1 owning with m1_write_en=1, addr 0x0080, data 0x0402, then m1_req drops -> exactly one bus write of 0x0402 at 0x0080; one idle cycle with bus_write_en=0; then owner=01.
- m0 writing every cycle, m1 idle for 20 cycles -> m0 keeps the bus with no forced switch. Raise m1_req -> switch within hold_max cycles; memory_tester content_ok asserts for the expected array.
- Reset asserted mid-burst in OWN1 with write_en=1 -> bus_write_en=0 immediately (asynchronous). After release, the first grant goes to master 0.
